// File: rtl/dvp_stream_packer.sv
// DVP camera byte stream to AXI-stream word packer.
// Registers the camera inputs, packs href-qualified bytes into OUT_BYTES-wide
// words (lane 0 first), marks line ends with tlast and frame starts with tuser,
// and buffers words in a first-word-fall-through FIFO. A FIFO overflow drops
// the rest of the frame.
module dvp_stream_packer #(
  parameter int OUT_BYTES         = 4,
  parameter int FIFO_DEPTH        = 16,
  parameter int VSYNC_ACTIVE_HIGH = 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   enable,
  input  logic [7:0]             cam_d,
  input  logic                   cam_href,
  input  logic                   cam_vsync,
  output logic [8*OUT_BYTES-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   overflow,
  output logic [15:0]            frame_count,
  output logic [15:0]            drop_count
);

  localparam int W  = 8 * OUT_BYTES;
  localparam int LW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = W + OUT_BYTES + 2;
  localparam logic [LW-1:0] LAST_LANE = LW'(OUT_BYTES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_LINE = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  // Registered camera inputs; vsync is stored already normalised to "active"
  logic [7:0] d_q;
  logic       href_q;
  logic       vs_act_q;
  logic       vs_prev_q;
  logic       vs_edge;

  // Packer state
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          stg_valid_q, stg_valid_d;
  logic [W-1:0]  stg_data_q, stg_data_d;
  logic          tuser_pend_q, tuser_pend_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  // FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fifo_full;
  logic          rd_en;
  logic [EW-1:0] head;

  // Write request built by the packer
  logic                 wr_req;
  logic                 wr_en;
  logic [W-1:0]         wr_data;
  logic [OUT_BYTES-1:0] wr_keep;
  logic                 wr_last;
  logic [W-1:0]         byte_word;
  logic [OUT_BYTES-1:0] part_keep;

  // Input capture: one register stage on every camera signal
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      d_q       <= 8'd0;
      href_q    <= 1'b0;
      vs_act_q  <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      d_q       <= cam_d;
      href_q    <= cam_href;
      vs_act_q  <= (VSYNC_ACTIVE_HIGH != 0) ? cam_vsync : ~cam_vsync;
      vs_prev_q <= vs_act_q;
    end
  end

  assign vs_edge = vs_act_q & ~vs_prev_q;

  // Accumulator with the incoming byte merged into the current lane, plus the partial-word keep mask
  always_comb begin
    byte_word = acc_q;
    part_keep = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (lane_q == LW'(i)) byte_word[8*i +: 8] = d_q;
      if (LW'(i) < lane_q) part_keep[i] = 1'b1;
    end
  end

  assign m_axis_tvalid = (cnt_q != '0);
  assign fifo_full     = (cnt_q == FULL_CNT);
  assign rd_en         = m_axis_tvalid & m_axis_tready;

  // Frame/line sequencing, packing, stage flush and overflow handling
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    lane_d       = lane_q;
    stg_valid_d  = stg_valid_q;
    stg_data_d   = stg_data_q;
    tuser_pend_d = tuser_pend_q;
    overflow_d   = overflow_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    wr_req       = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    wr_keep      = '0;
    wr_last      = 1'b0;

    if (vs_edge) begin
      // Frame boundary: anything half-built is thrown away
      acc_d       = '0;
      lane_d      = '0;
      stg_valid_d = 1'b0;
      stg_data_d  = '0;
      if (state_q == S_ARM || state_q == S_LINE) frame_cnt_d = frame_cnt_q + 16'd1;
      state_d      = enable ? S_ARM : S_IDLE;
      tuser_pend_d = enable;
    end else if ((state_q == S_ARM || state_q == S_LINE) && href_q) begin
      state_d = S_LINE;
      // A new byte proves the staged word was not the last of the line
      if (stg_valid_q) begin
        wr_req      = 1'b1;
        wr_data     = stg_data_q;
        wr_keep     = '1;
        stg_valid_d = 1'b0;
      end
      if (lane_q == LAST_LANE) begin
        stg_valid_d = 1'b1;
        stg_data_d  = byte_word;
        acc_d       = '0;
        lane_d      = '0;
      end else begin
        acc_d  = byte_word;
        lane_d = lane_q + 1'b1;
      end
    end else if (state_q == S_LINE) begin
      // Line end: the staged word or the partial accumulator carries tlast.
      // Both cannot be pending at once, since a new byte always flushes the stage.
      state_d     = S_ARM;
      acc_d       = '0;
      lane_d      = '0;
      stg_valid_d = 1'b0;
      if (stg_valid_q) begin
        wr_req  = 1'b1;
        wr_data = stg_data_q;
        wr_keep = '1;
        wr_last = 1'b1;
      end else if (lane_q != '0) begin
        wr_req  = 1'b1;
        wr_data = acc_q;
        wr_keep = part_keep;
        wr_last = 1'b1;
      end
    end

    if (wr_req) begin
      if (fifo_full && !rd_en) begin
        overflow_d  = 1'b1;
        drop_cnt_d  = drop_cnt_q + 16'd1;
        state_d     = S_DROP;
        acc_d       = '0;
        lane_d      = '0;
        stg_valid_d = 1'b0;
      end else begin
        wr_en        = 1'b1;
        tuser_pend_d = 1'b0;
      end
    end
  end

  // Packer and status registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      lane_q       <= '0;
      stg_valid_q  <= 1'b0;
      stg_data_q   <= '0;
      tuser_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_cnt_q  <= 16'd0;
      drop_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      lane_q       <= lane_d;
      stg_valid_q  <= stg_valid_d;
      stg_data_q   <= stg_data_d;
      tuser_pend_q <= tuser_pend_d;
      overflow_q   <= overflow_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  // FIFO pointer registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents need no reset because tvalid gates every output
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {tuser_pend_q, wr_last, wr_keep, wr_data};
  end

  assign head          = mem[rd_ptr_q];
  assign m_axis_tdata  = m_axis_tvalid ? head[W-1:0] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? head[W +: OUT_BYTES] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[W + OUT_BYTES];
  assign m_axis_tuser  = m_axis_tvalid & head[W + OUT_BYTES + 1];
  assign overflow      = overflow_q;
  assign frame_count   = frame_cnt_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_dvp_stream_packer.sv
// Testbench for dvp_stream_packer: randomized camera lines checked against a
// line-chunking reference model; second instance covers 1-byte words with
// active-low vsync.
module tb_dvp_stream_packer;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, enable, cam_href, cam_vsync, m_tready;
  logic [7:0]  cam_d;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, tuser, ovf;
  logic [15:0] fcnt, dcnt;

  logic        c1_en, c1_href, c1_vsync, c1_ready;
  logic [7:0]  c1_d, c1_tdata;
  logic        c1_tkeep, c1_tvalid, c1_tlast, c1_tuser, c1_ovf;
  logic [15:0] c1_fcnt, c1_dcnt;

  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;   // 0: tready=1, 1: random, 2: tready=0

  logic [37:0] exp_q[$], act_q[$], exp1_q[$], act1_q[$];

  // Reference model state
  bit          first_pend, frame_open, dropped;
  logic [15:0] m_frames, m_drops;

  dvp_stream_packer #(.OUT_BYTES(4), .FIFO_DEPTH(16), .VSYNC_ACTIVE_HIGH(1)) u0 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .cam_d(cam_d), .cam_href(cam_href),
    .cam_vsync(cam_vsync), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
    .m_axis_tvalid(tvalid), .m_axis_tready(m_tready), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser), .overflow(ovf), .frame_count(fcnt), .drop_count(dcnt)
  );

  dvp_stream_packer #(.OUT_BYTES(1), .FIFO_DEPTH(4), .VSYNC_ACTIVE_HIGH(0)) u1 (
    .clk(clk), .arst_n(arst_n), .enable(c1_en), .cam_d(c1_d), .cam_href(c1_href),
    .cam_vsync(c1_vsync), .m_axis_tdata(c1_tdata), .m_axis_tkeep(c1_tkeep),
    .m_axis_tvalid(c1_tvalid), .m_axis_tready(c1_ready), .m_axis_tlast(c1_tlast),
    .m_axis_tuser(c1_tuser), .overflow(c1_ovf), .frame_count(c1_fcnt), .drop_count(c1_dcnt)
  );

  // Output monitor: a transfer happens at the next posedge when valid&ready at the negedge
  always @(negedge clk) begin
    if (tvalid && m_tready) begin
      act_q.push_back({tuser, tlast, tkeep, tdata});
      $display("u0 xfer data=%h keep=%h last=%b user=%b", tdata, tkeep, tlast, tuser);
    end
    if (c1_tvalid && c1_ready) begin
      act1_q.push_back({27'd0, c1_tuser, c1_tlast, c1_tkeep, c1_tdata});
      $display("u1 xfer data=%h keep=%b last=%b user=%b", c1_tdata, c1_tkeep, c1_tlast, c1_tuser);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(3) != 0);
      default: m_tready = 1'b0;
    endcase
  endtask

  // Model: split a line into 4-byte words, lane 0 first, last word padded and tagged
  task automatic model_line(input bq_t b);
    int n = b.size();
    for (int i = 0; i < n; i += 4) begin
      logic [31:0] d = '0;
      logic [3:0]  k = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < n) begin
          d[8*j +: 8] = b[i+j];
          k[j] = 1'b1;
        end
      end
      exp_q.push_back({first_pend, (i + 4 >= n), k, d});
      first_pend = 1'b0;
    end
  endtask

  task automatic model_vsync(input bit en);
    if (frame_open && !dropped) m_frames = m_frames + 16'd1;
    frame_open = en;
    dropped    = 1'b0;
    first_pend = en;
  endtask

  task automatic model_reset();
    frame_open = 0; dropped = 0; first_pend = 0;
    m_frames = 16'd0; m_drops = 16'd0;
    exp_q.delete(); act_q.delete(); exp1_q.delete(); act1_q.delete();
  endtask

  task automatic send_vsync(input bit en);
    enable = en;
    cam_vsync = 1'b1;
    repeat (2) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    model_vsync(en);
  endtask

  task automatic send_line(input bq_t b, input int gap);
    if (frame_open && !dropped) model_line(b);
    foreach (b[i]) begin
      cam_href = 1'b1;
      cam_d = b[i];
      tick();
    end
    cam_href = 1'b0;
    cam_d = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (act_q.size() < exp_q.size() && n < 400) begin
      tick();
      n++;
    end
    repeat (6) tick();
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (3) tick();
    vectors += 8;
    if (tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    if (tdata !== 32'd0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    if (tkeep !== 4'd0) begin miscompares++; $display("FAIL reset_tkeep: got %h want 0", tkeep); end
    if (tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b want 0", tlast); end
    if (tuser !== 1'b0) begin miscompares++; $display("FAIL reset_tuser: got %b want 0", tuser); end
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", ovf); end
    if (fcnt !== 16'd0) begin miscompares++; $display("FAIL reset_frame_count: got %0d want 0", fcnt); end
    if (dcnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop_count: got %0d want 0", dcnt); end
    arst_n = 1'b1;
    model_reset();
    repeat (3) tick();
    vectors++;
    if (tvalid !== 1'b0) begin miscompares++; $display("FAIL post_reset_tvalid: got %b want 0", tvalid); end
  endtask

  task automatic test_basic();
    bq_t b = {};
    for (int i = 1; i <= 8; i++) b.push_back(8'(i));
    send_vsync(1'b1);
    send_line(b, 3);
    wait_drain();
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d words want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_word%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
    send_vsync(1'b1);
    vectors++;
    if (fcnt !== m_frames) begin miscompares++; $display("FAIL basic_frame_count: got %0d want %0d", fcnt, m_frames); end
  endtask

  task automatic test_partial();
    bq_t b = {};
    for (int i = 0; i < 6; i++) b.push_back(8'hA0 + 8'(i));
    send_line(b, 2);
    wait_drain();
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL partial_count: got %0d words want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL partial_word%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      send_vsync(1'b1);
      for (int l = 0; l < int'($urandom_range(4, 1)); l++) begin
        bq_t b = {};
        int len = int'($urandom_range(20, 1));
        for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        send_line(b, int'($urandom_range(4, 1)));
      end
      wait_drain();
      vectors++;
      if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL random_count f%0d: got %0d words want %0d", f, act_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < act_q.size()) begin
        vectors++;
        if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL random_word f%0d.%0d: got %h want %h", f, i, act_q[i], exp_q[i]); end
      end
      exp_q.delete(); act_q.delete();
    end
    send_vsync(1'b1);
    ready_mode = 0;
    tick();
    vectors++;
    if (fcnt !== m_frames) begin miscompares++; $display("FAIL random_frame_count: got %0d want %0d", fcnt, m_frames); end
  endtask

  task automatic test_overflow();
    bq_t b = {};
    logic [37:0] hold;
    ready_mode = 2;
    tick();
    send_vsync(1'b1);
    for (int i = 0; i < 100; i++) b.push_back(8'($urandom));
    send_line(b, 3);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    dropped = 1'b1;
    m_drops = m_drops + 16'd1;
    vectors += 3;
    if (ovf !== 1'b1) begin miscompares++; $display("FAIL overflow_flag: got %b want 1", ovf); end
    if (dcnt !== m_drops) begin miscompares++; $display("FAIL overflow_drop_count: got %0d want %0d", dcnt, m_drops); end
    if (tvalid !== 1'b1) begin miscompares++; $display("FAIL overflow_tvalid: got %b want 1", tvalid); end
    hold = {tuser, tlast, tkeep, tdata};
    repeat (3) tick();
    vectors++;
    if ({tuser, tlast, tkeep, tdata} !== hold) begin miscompares++; $display("FAIL overflow_hold: got %h want %h", {tuser, tlast, tkeep, tdata}, hold); end
    ready_mode = 0;
    wait_drain();
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL overflow_count: got %0d words want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL overflow_word%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
    send_vsync(1'b1);
    b = {};
    for (int i = 0; i < 10; i++) b.push_back(8'($urandom));
    send_line(b, 2);
    wait_drain();
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL recover_count: got %0d words want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL recover_word%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
    send_vsync(1'b1);
    vectors += 2;
    if (fcnt !== m_frames) begin miscompares++; $display("FAIL recover_frame_count: got %0d want %0d", fcnt, m_frames); end
    if (ovf !== 1'b1) begin miscompares++; $display("FAIL overflow_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_enable();
    bq_t b = {};
    for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
    send_vsync(1'b0);
    send_line(b, 2);
    send_line(b, 2);
    repeat (8) tick();
    send_vsync(1'b1);
    b = {};
    for (int i = 0; i < 7; i++) b.push_back(8'($urandom));
    send_line(b, 2);
    wait_drain();
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL enable_count: got %0d words want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL enable_word%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
    send_vsync(1'b1);
    vectors++;
    if (fcnt !== m_frames) begin miscompares++; $display("FAIL enable_frame_count: got %0d want %0d", fcnt, m_frames); end
  endtask

  task automatic test_reset_midline();
    bq_t b = {};
    for (int i = 0; i < 3; i++) begin
      cam_href = 1'b1;
      cam_d = 8'($urandom);
      tick();
    end
    #2;
    arst_n = 1'b0;
    #1;
    vectors += 5;
    if (tvalid !== 1'b0) begin miscompares++; $display("FAIL midreset_tvalid: got %b want 0", tvalid); end
    if (tdata !== 32'd0) begin miscompares++; $display("FAIL midreset_tdata: got %h want 0", tdata); end
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL midreset_overflow: got %b want 0", ovf); end
    if (fcnt !== 16'd0) begin miscompares++; $display("FAIL midreset_frame_count: got %0d want 0", fcnt); end
    if (dcnt !== 16'd0) begin miscompares++; $display("FAIL midreset_drop_count: got %0d want 0", dcnt); end
    cam_href = 1'b0;
    repeat (2) tick();
    arst_n = 1'b1;
    model_reset();
    repeat (10) tick();
    vectors++;
    if (act_q.size() != 0) begin miscompares++; $display("FAIL midreset_no_output: got %0d words want 0", act_q.size()); end
    send_vsync(1'b1);
    for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
    send_line(b, 2);
    wait_drain();
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midreset_count: got %0d words want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midreset_word%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_ob1();
    bit first = 1'b1;
    int n = 0;
    c1_en = 1'b1;
    // A rising edge alone must not start a frame for the active-low instance
    c1_vsync = 1'b0; repeat (2) tick();
    c1_vsync = 1'b1; repeat (3) tick();
    for (int l = 0; l < 2; l++) begin
      int len = int'($urandom_range(9, 3));
      for (int i = 0; i < len; i++) begin
        logic [7:0] v = 8'($urandom);
        exp1_q.push_back({27'd0, first, (i == len - 1), 1'b1, v});
        first = 1'b0;
        c1_href = 1'b1;
        c1_d = v;
        tick();
      end
      c1_href = 1'b0;
      repeat (3) tick();
    end
    while (act1_q.size() < exp1_q.size() && n < 200) begin tick(); n++; end
    repeat (4) tick();
    vectors++;
    if (act1_q.size() != exp1_q.size()) begin miscompares++; $display("FAIL ob1_count: got %0d words want %0d", act1_q.size(), exp1_q.size()); end
    foreach (exp1_q[i]) if (i < act1_q.size()) begin
      vectors++;
      if (act1_q[i] !== exp1_q[i]) begin miscompares++; $display("FAIL ob1_word%0d: got %h want %h", i, act1_q[i], exp1_q[i]); end
    end
    c1_vsync = 1'b0; repeat (2) tick();
    c1_vsync = 1'b1; repeat (3) tick();
    vectors++;
    if (c1_fcnt !== 16'd1) begin miscompares++; $display("FAIL ob1_frame_count: got %0d want 1", c1_fcnt); end
  endtask

  initial begin
    arst_n = 1'b0; enable = 1'b1; cam_href = 1'b0; cam_vsync = 1'b0; cam_d = 8'd0; m_tready = 1'b1;
    c1_en = 1'b1; c1_href = 1'b0; c1_vsync = 1'b1; c1_d = 8'd0; c1_ready = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_partial();
    test_random();
    test_overflow();
    test_enable();
    test_reset_midline();
    test_ob1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dvp_stream_packer.md
DVP_STREAM_PACKER -- requirements
Module: dvp_stream_packer

Interface
REQ-001 Parameter OUT_BYTES, default 4: output word width in bytes, legal values 1, 2, 4 and 8.
REQ-002 Parameter FIFO_DEPTH, default 16: output FIFO depth in words, a power of 2, at least 4.
REQ-003 Parameter VSYNC_ACTIVE_HIGH, default 1: 1 means a frame starts on the vsync rising edge; 0 means it starts on the falling edge.
REQ-004 clk  in  1  pixel clock; the block uses this single clock domain.
REQ-005 arst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  capture enable, sampled only at frame start.
REQ-007 cam_d  in  8  DVP data byte.
REQ-008 cam_href  in  1  line-valid, active high.
REQ-009 cam_vsync  in  1  frame sync, polarity set by VSYNC_ACTIVE_HIGH.
REQ-010 m_axis_tdata  out  8*OUT_BYTES  packed bytes; the first byte of the word is in lane 0 (LSBs).
REQ-011 m_axis_tkeep  out  OUT_BYTES  valid-lane mask.
REQ-012 m_axis_tvalid / m_axis_tready  out / in  1 each  AXI-stream handshake.
REQ-013 m_axis_tlast  out  1  marks the final word of a line.
REQ-014 m_axis_tuser  out  1  marks the first word of a frame.
REQ-015 overflow  out  1  sticky flag; cleared only by reset.
REQ-016 frame_count  out  16  number of frames completed without drop; wraps.
REQ-017 drop_count  out  16  number of frames truncated by overflow; wraps.

Function
REQ-018 Input path: cam_d, cam_href and cam_vsync are registered once before any use, giving 1 cycle of input latency.
REQ-019 States:
- IDLE: entered from reset; on a registered vsync active edge with enable=1, go to ARM; with enable=0, stay in IDLE.
- ARM: wait for href=1, then go to LINE.
- LINE: capture bytes while href=1.
- DROP: discard all input until the next vsync active edge.
REQ-020 In any capture state, a vsync active edge ends the current frame:
- with enable=1, go to ARM;
- with enable=0, go to IDLE;
- any partial word is discarded and not emitted.
REQ-021 LINE packing: each registered byte with href=1 fills the next lane of the accumulator.
REQ-022 Completed words (all OUT_BYTES lanes filled) go to a one-word stage register.
REQ-023 A staged word is written to the FIFO when either of these occurs first:
- the next href=1 byte is registered: write with tlast=0;
- href=0 is registered: write with tlast=1.
REQ-024 Line ends with a partial word (n filled lanes, 0<n<OUT_BYTES):
- the partial word is written with tkeep equal to n low bits set, tlast=1;
- unused lanes carry 0;
- a staged full word, if present, is written first with tlast=0.
REQ-025 Exactly one word per line carries tlast=1. A line ending exactly on a word boundary produces no extra empty word.
REQ-026 tuser=1 on the first word written after the vsync edge that started the frame; tuser=0 on every other word.
REQ-027 Accumulator lane pointer:
- wraps to 0 after lane OUT_BYTES-1;
- resets to 0 at every line end and every frame start.
REQ-028 FIFO behaviour:
- first-word fall-through;
- a word appears on m_axis no later than 4 cycles after its final byte was on cam_d, provided the FIFO is empty and tready=1;
- holding tready=0 keeps tdata, tkeep, tlast and tuser stable while tvalid=1.
REQ-029 A simultaneous FIFO read and write on a full FIFO is a legal write.
REQ-030 Overflow: a write attempted while the FIFO is full (and no simultaneous read) causes:
- the word is discarded;
- overflow is set to 1;
- drop_count increments;
- state goes to DROP.
Words already in the FIFO still drain normally.
REQ-031 frame_count increments on the vsync active edge that ends a frame, provided the frame reached at least ARM and was not dropped.
REQ-032 The counters wrap from 16'hFFFF to 0.
REQ-033 Bytes received while href=1 in IDLE, ARM-before-href or DROP are ignored.

Reset
REQ-034 While arst_n=0, all registers clear asynchronously:
- state=IDLE;
- FIFO empty, m_axis_tvalid=0, tdata/tkeep/tlast/tuser=0;
- overflow=0, frame_count=0, drop_count=0, accumulator and stage empty.
REQ-035 Reset release takes effect on the first clk edge after arst_n rises. Reset asserted mid-line discards all buffered data, and no word is emitted.

Verification
REQ-036 With OUT_BYTES=4, enable=1, tready=1: one vsync pulse, then href high for 8 bytes 0x01..0x08 → two words 0x04030201 (tuser=1, tlast=0) and 0x08070605 (tkeep=4'hF, tlast=1); after the next vsync edge, frame_count=1.
REQ-037 A line of 6 bytes 0xA0..0xA5 → 0xA3A2A1A0 (tkeep=F, tlast=0), then 0x0000A5A4 (tkeep=4'h3, tlast=1).
REQ-038 tready=0 with FIFO_DEPTH=16 and a 100-byte line → 16 words accepted, then overflow=1, drop_count=1, state DROP; after tready=1, exactly 16 words drain; the next frame captures normally and frame_count is unchanged.
REQ-039 enable=0 at a vsync edge → no output for that frame; enable=1 at the following edge → capture resumes, first word has tuser=1.
REQ-040 arst_n pulsed low during a line after 3 bytes → outputs immediately zero, no partial word emitted; the next frame starts clean with tuser=1.
REQ-041 With VSYNC_ACTIVE_HIGH=0 and OUT_BYTES=1: every byte is emitted as its own word with tkeep=1'b1; tlast=1 only on the last byte of the line; the frame starts on the vsync falling edge.
